// File: rtl/lsu_pkg.sv
// lsu_pkg - shared encodings for the MEM-stage load/store unit:
// access-size codes, FSM state enum, lane width and small decode helpers.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam int LANE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_MRG  = 3'd2,
      ST_WR   = 3'd3,
      ST_LD   = 3'd4
   } lsu_state_t;

   // True when the access cannot be served at this address without wrapping a lane.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lo[0];
         SZ_WORD: mis = (lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

   // The reserved size code behaves as a full word when it is not trapped.
   function automatic logic is_full_word(input logic [1:0] size);
      return (size == SZ_WORD) || (size == SZ_RSVD);
   endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux - combinational lane steering shared by the load and merge paths.
// load_data: selected byte/half of mem_word, sign- or zero-extended.
// merge_data: mem_word with the selected lane(s) replaced by the low bits of wdata.
// Half accesses look only at addr_lo[1]; word accesses ignore addr_lo.
module lsu_lane_mux
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] mem_word,
   input  logic [1:0]        addr_lo,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] merge_data
);

   localparam int HALF_W = 2 * LANE_W;

   logic [LANE_W-1:0] byte_sel;
   logic [HALF_W-1:0] half_sel;

   // Pick the addressed byte and half out of the memory word (little-endian lanes).
   always_comb begin
      byte_sel = mem_word[LANE_W-1:0];
      case (addr_lo)
         2'b00:   byte_sel = mem_word[7:0];
         2'b01:   byte_sel = mem_word[15:8];
         2'b10:   byte_sel = mem_word[23:16];
         2'b11:   byte_sel = mem_word[31:24];
         default: byte_sel = mem_word[7:0];
      endcase
      if (addr_lo[1]) begin
         half_sel = mem_word[31:16];
      end else begin
         half_sel = mem_word[15:0];
      end
   end

   // Extend the selected lane to a full load result.
   always_comb begin
      load_data = mem_word;
      case (size)
         SZ_BYTE: begin
            if (sext) begin
               load_data = {{(DATA_W-LANE_W){byte_sel[LANE_W-1]}}, byte_sel};
            end else begin
               load_data = {{(DATA_W-LANE_W){1'b0}}, byte_sel};
            end
         end
         SZ_HALF: begin
            if (sext) begin
               load_data = {{(DATA_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            end else begin
               load_data = {{(DATA_W-HALF_W){1'b0}}, half_sel};
            end
         end
         default: load_data = mem_word;
      endcase
   end

   // Overlay the store data onto the old word for read-modify-write.
   always_comb begin
      merge_data = mem_word;
      case (size)
         SZ_BYTE: begin
            case (addr_lo)
               2'b00:   merge_data[7:0]   = wdata[7:0];
               2'b01:   merge_data[15:8]  = wdata[7:0];
               2'b10:   merge_data[23:16] = wdata[7:0];
               2'b11:   merge_data[31:24] = wdata[7:0];
               default: merge_data[7:0]   = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (addr_lo[1]) begin
               merge_data[31:16] = wdata[15:0];
            end else begin
               merge_data[15:0] = wdata[15:0];
            end
         end
         default: merge_data = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_memstage.sv
// lsu_memstage - MEM-stage load/store unit in front of a 1-cycle-latency
// word memory. Sub-word stores are read-modify-write; loads are lane
// extracted and extended. Optional macro LSU_MISALIGN_TRAP_EN makes
// misaligned requests complete immediately with err=1 and no memory access.
module lsu_memstage
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              busy,
   output logic              err,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   lsu_state_t state, next_state;

   logic [1:0]        addr_lo_r;
   logic [1:0]        size_r;
   logic              sext_r;
   logic              we_r;
   logic [DATA_W-1:0] wdata_r;

   logic              misalign_s;
   logic              accept_s;
   logic              trap_s;
   logic              start_s;
   logic              finish_s;
   logic [DATA_W-1:0] load_data_s;
   logic [DATA_W-1:0] merge_data_s;

   // Bits above the 4 KiB window are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_s = is_misaligned(size, addr[1:0]);
`else
   assign misalign_s = 1'b0;
`endif

   assign accept_s = req && (state == ST_IDLE);

   lsu_lane_mux #(.DATA_W(DATA_W)) u_lane_mux (
      .mem_word   (mem_dout),
      .addr_lo    (addr_lo_r),
      .size       (size_r),
      .sext       (sext_r),
      .wdata      (wdata_r),
      .load_data  (load_data_s),
      .merge_data (merge_data_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state = ST_IDLE;
      case (state)
         ST_IDLE: begin
            if (req && !misalign_s) begin
               if (we && is_full_word(size)) begin
                  next_state = ST_WR;
               end else begin
                  next_state = ST_RD;
               end
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_RD: begin
            if (we_r) begin
               next_state = ST_MRG;
            end else begin
               next_state = ST_LD;
            end
         end
         ST_MRG:  next_state = ST_WR;
         ST_WR:   next_state = ST_IDLE;
         ST_LD:   next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Control strobes that feed the registered outputs.
   always_comb begin
      trap_s   = accept_s && misalign_s;
      start_s  = accept_s && !misalign_s;
      finish_s = (state != ST_IDLE) && (next_state == ST_IDLE);
   end

   // Capture the request fields when a memory operation starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_lo_r <= 2'b00;
         size_r    <= SZ_BYTE;
         sext_r    <= 1'b0;
         we_r      <= 1'b0;
         wdata_r   <= {DATA_W{1'b0}};
      end else if (start_s) begin
         addr_lo_r <= addr[1:0];
         size_r    <= size;
         sext_r    <= sext;
         we_r      <= we;
         wdata_r   <= wdata;
      end else begin
         addr_lo_r <= addr_lo_r;
         size_r    <= size_r;
         sext_r    <= sext_r;
         we_r      <= we_r;
         wdata_r   <= wdata_r;
      end
   end

   // Registered handshake and memory-port outputs, derived from the upcoming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata    <= {DATA_W{1'b0}};
         done     <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
         mem_rw   <= 1'b0;
         mem_addr <= {ADDR_W{1'b0}};
         mem_din  <= {DATA_W{1'b0}};
      end else begin
         done   <= finish_s || trap_s;
         err    <= trap_s;
         busy   <= (next_state != ST_IDLE);
         mem_rw <= (next_state == ST_WR);

         if (start_s) begin
            mem_addr <= addr[ADDR_W+1:2];
         end else begin
            mem_addr <= mem_addr;
         end

         if (trap_s) begin
            rdata <= {DATA_W{1'b0}};
         end else if (state == ST_LD) begin
            rdata <= load_data_s;
         end else begin
            rdata <= rdata;
         end

         // mem_din doubles as the write buffer for the WR cycle.
         if (start_s && (next_state == ST_WR)) begin
            mem_din <= wdata;
         end else if (state == ST_MRG) begin
            mem_din <= merge_data_s;
         end else begin
            mem_din <= mem_din;
         end
      end
   end

endmodule

// File: tb/tb_lsu_memstage.sv
// tb_lsu_memstage - self-checking bench for lsu_memstage with a behavioural
// word memory (1-cycle read latency) and a byte-array reference model.
module tb_lsu_memstage;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        busy;
   logic        err;
   logic        mem_rw;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   int n_cmp = 0;
   int n_bad = 0;
   int done_hits;
   int wr_hits;

   logic [31:0] dm [0:1023];
   logic [7:0]  ref_mem [0:4095];
   logic [31:0] last_rd;

   lsu_memstage #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .we       (we),
      .size     (size),
      .sext     (sext),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .done     (done),
      .busy     (busy),
      .err      (err),
      .mem_rw   (mem_rw),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   always #5 clk = ~clk;

   // Behavioural datamemory: synchronous write, registered read.
   always @(posedge clk) begin
      if (mem_rw) dm[mem_addr] <= mem_din;
      mem_dout <= dm[mem_addr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int widx);
      return {ref_mem[4*widx+3], ref_mem[4*widx+2], ref_mem[4*widx+1], ref_mem[4*widx]};
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rdata"}, rdata, 32'h0);
      check({tag, "_done"}, {31'd0, done}, 32'h0);
      check({tag, "_busy"}, {31'd0, busy}, 32'h0);
      check({tag, "_err"}, {31'd0, err}, 32'h0);
      check({tag, "_mem_rw"}, {31'd0, mem_rw}, 32'h0);
      check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'h0);
      check({tag, "_mem_din"}, mem_din, 32'h0);
   endtask

   // Issue one request at the current negedge, follow it to done, check against the model.
   // Returns at the negedge of the done cycle so the next request is issued back-to-back.
   task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
      int ea, nb, base, exp_cyc, wr_cnt, wr_cyc, done_cyc;
      logic mis, trap, err_seen, busy1;
      logic [31:0] exp_rd, v, wr_addr;
      ea = int'(a & 32'h0000_0FFF);
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      trap = mis;
`else
      trap = 1'b0;
`endif
      base = ea - (ea % nb);
      exp_rd = 32'h0;
      if (trap) begin
         exp_cyc = 1;
      end else if (w) begin
         for (int i = 0; i < nb; i++) ref_mem[base+i] = wd[8*i +: 8];
         exp_cyc = (nb == 4) ? 2 : 4;
      end else begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = v | ({24'd0, ref_mem[base+i]} << (8*i));
         if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
         exp_rd = v;
         exp_cyc = 3;
      end

      we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
      done_cyc = 0; wr_cnt = 0; wr_cyc = 0; busy1 = 1'b0; wr_addr = 32'h0; err_seen = 1'b0;
      for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req = 1'b0;
            busy1 = busy;
         end
         if (mem_rw) begin
            wr_cnt++;
            wr_cyc = c;
            wr_addr = {22'd0, mem_addr};
         end
         if (done) begin
            done_cyc = c;
            err_seen = err;
            last_rd = rdata;
         end
      end

      check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
      check({tag, "_err"}, {31'd0, err_seen}, {31'd0, trap});
      check({tag, "_busy_cycle1"}, {31'd0, busy1}, {31'd0, !trap});
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'h0);
      check({tag, "_write_count"}, 32'(wr_cnt), (w && !trap) ? 32'd1 : 32'd0);
      if (w && !trap) begin
         check({tag, "_write_cycle"}, 32'(wr_cyc), 32'(exp_cyc - 1));
         check({tag, "_write_addr"}, wr_addr, 32'(base / 4));
         check({tag, "_mem_word"}, dm[base/4], ref_word(base / 4));
      end else begin
         check({tag, "_rdata"}, last_rd, exp_rd);
      end
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
      addr = 32'h0; wdata = 32'h0; last_rd = 32'h0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Fill the 16-word test window through the unit itself.
      for (int i = 0; i < 16; i++) run_op(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, "init_sw");

      run_op(1'b1, 2'b10, 1'b0, 32'h020, 32'h80FF7F01, "sw");
      check("sw_word8", dm[8], 32'h80FF7F01);
      run_op(1'b0, 2'b00, 1'b1, 32'h022, 32'h0, "lb");
      check("lb_value", last_rd, 32'hFFFFFFFF);
      run_op(1'b0, 2'b00, 1'b0, 32'h022, 32'h0, "lbu");
      check("lbu_value", last_rd, 32'h000000FF);
      run_op(1'b0, 2'b01, 1'b1, 32'h022, 32'h0, "lh");
      check("lh_value", last_rd, 32'hFFFF80FF);
      run_op(1'b0, 2'b01, 1'b0, 32'h020, 32'h0, "lhu");
      check("lhu_value", last_rd, 32'h00007F01);
      run_op(1'b1, 2'b00, 1'b0, 32'h021, 32'h000000AA, "sb");
      check("sb_word8", dm[8], 32'h80FFAA01);
      run_op(1'b0, 2'b01, 1'b1, 32'h021, 32'h0, "lh_misaligned");
`ifdef LSU_MISALIGN_TRAP_EN
      check("lh_misaligned_value", last_rd, 32'h00000000);
`else
      check("lh_misaligned_value", last_rd, 32'hFFFFAA01);
`endif
      run_op(1'b0, 2'b10, 1'b0, 32'hABCD_F020, 32'h0, "lw_wrap");
      check("lw_wrap_value", last_rd, 32'h80FFAA01);

      // Randomized back-to-back traffic inside the initialised window.
      for (int k = 0; k < 200; k++) begin
         logic [31:0] ra;
         ra = $urandom;
         ra[11:6] = 6'd0;
         run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ra, $urandom, "rand");
      end

      // Reset during the merge cycle of a half store must not touch memory.
      we = 1'b1; size = 2'b01; sext = 1'b0; addr = 32'h024; wdata = 32'h0000BEEF; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("rst_busy_rd", {31'd0, busy}, 32'h1);
      @(negedge clk);
      check("rst_busy_mrg", {31'd0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      check_outputs_zero("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      done_hits = 0;
      wr_hits = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) done_hits++;
         if (mem_rw) wr_hits++;
      end
      check("rst_no_done", 32'(done_hits), 32'h0);
      check("rst_no_write", 32'(wr_hits), 32'h0);
      check("rst_word9", dm[9], ref_word(9));
      run_op(1'b0, 2'b10, 1'b0, 32'h024, 32'h0, "lw_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
